// File: rtl/i2c_target_responder.sv
// Single-address I2C target: oversampled START/STOP detection, address match, write delivery and
// read sourcing through a request/load handshake. Define I2C_TARGET_STRETCH_EN to stretch SCL
// instead of sending 8'hFF when a read byte is not ready.
module i2c_target_responder #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCL_i,
    input  logic       SDA_i,
    output logic       SDA_o,
    output logic       SDA_OE,
    output logic       SCL_OE,
    output logic [7:0] RxDATA,
    output logic       RxVALID,
    input  logic [7:0] TxDATA,
    output logic       TxREQ,
    input  logic       TxLOAD,
    output logic       TxUNDERRUN,
    output logic       MasterNACK,
    output logic       Selected,
    output logic       StartDet,
    output logic       StopDet
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StWaitStop
    } stateT;

    stateT                  stateQ, stateD;
    logic [SYNC_STAGES-1:0] sclSync, sdaSync;
    logic                   sclPrev, sdaPrev;
    logic                   sclS, sdaS, sclRise, sclFall, startCond, stopCond;
    logic [3:0]             bitCntQ, bitCntD;
    logic [7:0]             shiftQ, shiftD, holdQ, holdD, rxDataQ, rxDataD, loadByte;
    logic                   rwQ, rwD, holdValidQ, holdValidD, haveByte, doReload;
    logic                   rxValidQ, rxValidD, txReqQ, txReqD, underrunQ, underrunD;
    logic                   nackQ, nackD, selectedQ, selectedD, startQ, startD, stopQ, stopD;
    logic                   sdaOeQ, sdaOeD, sdaOutQ, sdaOutD;
`ifdef I2C_TARGET_STRETCH_EN
    logic                   stretchQ, stretchD;
`endif

    assign sclS      = sclSync[SYNC_STAGES-1];
    assign sdaS      = sdaSync[SYNC_STAGES-1];
    assign sclRise   = sclS & ~sclPrev;
    assign sclFall   = ~sclS & sclPrev;
    assign startCond = sclS & sclPrev & sdaPrev & ~sdaS;
    assign stopCond  = sclS & sclPrev & ~sdaPrev & sdaS;

    // A strobe in the reload cycle wins over the holding register.
    assign haveByte = TxLOAD | holdValidQ;
    assign loadByte = TxLOAD ? TxDATA : (holdValidQ ? holdQ : 8'hFF);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclSync    <= '1;
            sdaSync    <= '1;
            sclPrev    <= 1'b1;
            sdaPrev    <= 1'b1;
            stateQ     <= StIdle;
            bitCntQ    <= 4'd0;
            shiftQ     <= 8'h00;
            rwQ        <= 1'b0;
            holdQ      <= 8'h00;
            holdValidQ <= 1'b0;
            rxDataQ    <= 8'h00;
            rxValidQ   <= 1'b0;
            txReqQ     <= 1'b0;
            underrunQ  <= 1'b0;
            nackQ      <= 1'b0;
            selectedQ  <= 1'b0;
            startQ     <= 1'b0;
            stopQ      <= 1'b0;
            sdaOeQ     <= 1'b0;
            sdaOutQ    <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            stretchQ   <= 1'b0;
`endif
        end else begin
            sclSync    <= {sclSync[SYNC_STAGES-2:0], SCL_i};
            sdaSync    <= {sdaSync[SYNC_STAGES-2:0], SDA_i};
            sclPrev    <= sclS;
            sdaPrev    <= sdaS;
            stateQ     <= stateD;
            bitCntQ    <= bitCntD;
            shiftQ     <= shiftD;
            rwQ        <= rwD;
            holdQ      <= holdD;
            holdValidQ <= holdValidD;
            rxDataQ    <= rxDataD;
            rxValidQ   <= rxValidD;
            txReqQ     <= txReqD;
            underrunQ  <= underrunD;
            nackQ      <= nackD;
            selectedQ  <= selectedD;
            startQ     <= startD;
            stopQ      <= stopD;
            sdaOeQ     <= sdaOeD;
            sdaOutQ    <= sdaOutD;
`ifdef I2C_TARGET_STRETCH_EN
            stretchQ   <= stretchD;
`endif
        end
    end

    always_comb begin
        stateD     = stateQ;
        bitCntD    = bitCntQ;
        shiftD     = shiftQ;
        rwD        = rwQ;
        holdD      = holdQ;
        holdValidD = holdValidQ;
        rxDataD    = rxDataQ;
        rxValidD   = 1'b0;
        txReqD     = 1'b0;
        underrunD  = underrunQ;
        nackD      = 1'b0;
        selectedD  = selectedQ;
        startD     = 1'b0;
        stopD      = 1'b0;
        sdaOeD     = sdaOeQ;
        sdaOutD    = sdaOutQ;
        doReload   = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
        stretchD   = stretchQ;
`endif

        if (TxLOAD) begin
            holdD      = TxDATA;
            holdValidD = 1'b1;
        end

        if (stopCond) begin
            stateD    = StIdle;
            stopD     = 1'b1;
            selectedD = 1'b0;
            sdaOeD    = 1'b0;
            sdaOutD   = 1'b0;
            bitCntD   = 4'd0;
`ifdef I2C_TARGET_STRETCH_EN
            stretchD  = 1'b0;
`endif
        end else if (startCond) begin
            stateD    = StAddr;
            startD    = 1'b1;
            underrunD = 1'b0;
            selectedD = 1'b0;
            sdaOeD    = 1'b0;
            sdaOutD   = 1'b0;
            bitCntD   = 4'd0;
            shiftD    = 8'h00;
`ifdef I2C_TARGET_STRETCH_EN
            stretchD  = 1'b0;
`endif
        end
`ifdef I2C_TARGET_STRETCH_EN
        else if (stretchQ) begin
            // SCL is held low; edges are frozen until the byte arrives.
            if (holdValidQ) begin
                stretchD   = 1'b0;
                shiftD     = holdQ;
                sdaOutD    = holdQ[7];
                sdaOeD     = 1'b1;
                holdValidD = TxLOAD;
                bitCntD    = 4'd0;
                stateD     = StRead;
            end
        end
`endif
        else begin
            case (stateQ)
                StAddr, StWrite: begin
                    if (sclRise) begin
                        shiftD  = {shiftQ[6:0], sdaS};
                        bitCntD = bitCntQ + 4'd1;
                    end else if (sclFall && bitCntQ == 4'd8) begin
                        bitCntD = 4'd0;
                        if (stateQ == StAddr) begin
                            if (shiftQ[7:1] == SLAVE_ADDR) begin
                                stateD    = StAddrAck;
                                rwD       = shiftQ[0];
                                txReqD    = shiftQ[0];
                                selectedD = 1'b1;
                                sdaOeD    = 1'b1;
                                sdaOutD   = 1'b0;
                            end else begin
                                stateD = StWaitStop;
                            end
                        end else begin
                            stateD   = StWriteAck;
                            rxDataD  = shiftQ;
                            rxValidD = 1'b1;
                            sdaOeD   = 1'b1;
                            sdaOutD  = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (sclFall) begin
                        if (rwQ) begin
                            doReload = 1'b1;
                        end else begin
                            stateD = StWrite;
                            sdaOeD = 1'b0;
                        end
                    end
                end
                StWriteAck: begin
                    if (sclFall) begin
                        stateD = StWrite;
                        sdaOeD = 1'b0;
                    end
                end
                StRead: begin
                    if (sclRise) begin
                        bitCntD = bitCntQ + 4'd1;
                    end else if (sclFall) begin
                        if (bitCntQ == 4'd8) begin
                            stateD  = StReadAck;
                            bitCntD = 4'd0;
                            sdaOeD  = 1'b0;
                        end else begin
                            sdaOutD = shiftQ[6];
                            shiftD  = {shiftQ[6:0], 1'b0};
                        end
                    end
                end
                StReadAck: begin
                    if (sclRise) begin
                        if (sdaS) begin
                            nackD  = 1'b1;
                            stateD = StWaitStop;
                        end else begin
                            txReqD = 1'b1;
                        end
                    end else if (sclFall) begin
                        doReload = 1'b1;
                    end
                end
                default: ;
            endcase

            if (doReload) begin
                holdValidD = 1'b0;
                bitCntD    = 4'd0;
                if (haveByte) begin
                    shiftD  = loadByte;
                    sdaOutD = loadByte[7];
                    sdaOeD  = 1'b1;
                    stateD  = StRead;
                end else begin
`ifdef I2C_TARGET_STRETCH_EN
                    stretchD = 1'b1;
                    sdaOeD   = 1'b0;
`else
                    underrunD = 1'b1;
                    shiftD    = 8'hFF;
                    sdaOutD   = 1'b1;
                    sdaOeD    = 1'b1;
                    stateD    = StRead;
`endif
                end
            end
        end
    end

    always_comb begin
        SDA_o      = sdaOutQ;
        SDA_OE     = sdaOeQ;
`ifdef I2C_TARGET_STRETCH_EN
        SCL_OE     = stretchQ;
`else
        SCL_OE     = 1'b0;
`endif
        RxDATA     = rxDataQ;
        RxVALID    = rxValidQ;
        TxREQ      = txReqQ;
        TxUNDERRUN = underrunQ;
        MasterNACK = nackQ;
        Selected   = selectedQ;
        StartDet   = startQ;
        StopDet    = stopQ;
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-level I2C master model drives the bus and
// hand-computed expectations are compared through checkVal.
module tb_i2c_target_responder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       sclM, sdaM, sclBus, sdaBus;
    logic       SDA_o, SDA_OE, SCL_OE, RxVALID, TxREQ, TxLOAD, TxUNDERRUN;
    logic       MasterNACK, Selected, StartDet, StopDet;
    logic [7:0] RxDATA, TxDATA;

    int checks = 0;
    int errors = 0;
    int rxCnt = 0, txReqCnt = 0, nackCnt = 0, startCnt = 0, stopCnt = 0, oeCnt = 0;
    int sclOeCnt = 0;
    logic [7:0] rxQ[$];

    assign sclBus = sclM & ~SCL_OE;
    assign sdaBus = sdaM & ~(SDA_OE & ~SDA_o);

    i2c_target_responder #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .SCL_i(sclBus), .SDA_i(sdaBus), .SDA_o(SDA_o),
        .SDA_OE(SDA_OE), .SCL_OE(SCL_OE), .RxDATA(RxDATA), .RxVALID(RxVALID),
        .TxDATA(TxDATA), .TxREQ(TxREQ), .TxLOAD(TxLOAD), .TxUNDERRUN(TxUNDERRUN),
        .MasterNACK(MasterNACK), .Selected(Selected), .StartDet(StartDet), .StopDet(StopDet)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RxVALID) begin
            rxCnt++;
            rxQ.push_back(RxDATA);
        end
        if (TxREQ) txReqCnt++;
        if (MasterNACK) nackCnt++;
        if (StartDet) startCnt++;
        if (StopDet) stopCnt++;
        if (SDA_OE) oeCnt++;
        if (SCL_OE) sclOeCnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, required finish before 800us");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] allOuts();
        return {SDA_o, SDA_OE, SCL_OE, RxDATA, RxVALID, TxREQ, TxUNDERRUN, MasterNACK,
                Selected, StartDet, StopDet};
    endfunction

    task automatic clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bitXfer(input logic b, output logic r, output logic oe);
        int t;
        sdaM = b;
        clk(3);
        sclM = 1'b1;
        t = 0;
        while (!sclBus && t < 2000) begin
            clk(1);
            t++;
        end
        if (!sclBus) checkVal("scl_release_timeout", sclBus, 1'b1);
        clk(4);
        r  = sdaBus;
        oe = SDA_OE;
        clk(4);
        sclM = 1'b0;
        clk(4);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack, output logic oe);
        logic r, o;
        for (int i = 7; i >= 0; i--) bitXfer(d[i], r, o);
        bitXfer(1'b1, r, oe);
        ack = ~r;
    endtask

    task automatic readByte(input logic ackBit, output logic [7:0] d);
        logic r, o;
        for (int i = 7; i >= 0; i--) begin
            bitXfer(1'b1, r, o);
            d[i] = r;
        end
        bitXfer(ackBit, r, o);
    endtask

    task automatic sendStart();
        sdaM = 1'b1;
        sclM = 1'b1;
        clk(4);
        sdaM = 1'b0;
        clk(6);
        sclM = 1'b0;
        clk(4);
    endtask

    task automatic sendRepStart();
        sdaM = 1'b1;
        clk(4);
        sclM = 1'b1;
        clk(6);
        sdaM = 1'b0;
        clk(6);
        sclM = 1'b0;
        clk(4);
    endtask

    task automatic sendStop();
        sdaM = 1'b0;
        clk(4);
        sclM = 1'b1;
        clk(6);
        sdaM = 1'b1;
        clk(6);
    endtask

    task automatic supply(input logic [7:0] v, input int delay);
        int t = 0;
        while (!TxREQ && t < 4000) begin
            clk(1);
            t++;
        end
        if (!TxREQ) checkVal("txreq_timeout", TxREQ, 1'b1);
        clk(delay);
        TxDATA = v;
        TxLOAD = 1'b1;
        clk(1);
        TxLOAD = 1'b0;
    endtask

    initial begin
        logic       ack, oe, r, o;
        logic [7:0] b1, b2;
        int         rx0, st0, tr0, n0, oe0, s0, so0;

        RESET  = 1'b1;
        sclM   = 1'b1;
        sdaM   = 1'b1;
        TxLOAD = 1'b0;
        TxDATA = 8'h00;
        clk(3);
        checkVal("reset_outputs", allOuts(), 18'h0);
        RESET = 1'b0;
        clk(5);

        // Write A5, 3C to address 0x50.
        rx0 = rxCnt;
        sendStart();
        writeByte(8'hA0, ack, oe);
        checkVal("wr_addr_ack", ack, 1'b1);
        checkVal("wr_addr_oe", oe, 1'b1);
        checkVal("wr_selected", Selected, 1'b1);
        writeByte(8'hA5, ack, oe);
        checkVal("wr_byte1_ack", {ack, oe}, 2'b11);
        writeByte(8'h3C, ack, oe);
        checkVal("wr_byte2_ack", {ack, oe}, 2'b11);
        checkVal("wr_rx_count", rxCnt - rx0, 2);
        checkVal("wr_rx_byte1", rxQ[rx0], 8'hA5);
        checkVal("wr_rx_byte2", rxQ[rx0 + 1], 8'h3C);
        st0 = stopCnt;
        sendStop();
        checkVal("wr_stop_pulse", stopCnt - st0, 1);
        checkVal("wr_stop_released", {Selected, SDA_OE}, 2'b00);

        // Address 0x51 must be ignored entirely.
        rx0 = rxCnt;
        oe0 = oeCnt;
        sendStart();
        writeByte(8'hA2, ack, oe);
        checkVal("nm_addr_nack", ack, 1'b0);
        writeByte(8'h55, ack, oe);
        sendStop();
        checkVal("nm_no_drive", oeCnt - oe0, 0);
        checkVal("nm_no_rx", rxCnt - rx0, 0);
        checkVal("nm_not_selected", Selected, 1'b0);

        // Read two bytes, ACK then NACK.
        tr0 = txReqCnt;
        n0  = nackCnt;
        fork
            begin
                sendStart();
                writeByte(8'hA1, ack, oe);
                readByte(1'b0, b1);
                readByte(1'b1, b2);
                sendStop();
            end
            begin
                supply(8'h96, 2);
                supply(8'h0F, 2);
            end
        join
        checkVal("rd_addr_ack", ack, 1'b1);
        checkVal("rd_byte1", b1, 8'h96);
        checkVal("rd_byte2", b2, 8'h0F);
        checkVal("rd_txreq_count", txReqCnt - tr0, 2);
        checkVal("rd_nack_count", nackCnt - n0, 1);
        checkVal("rd_released", {SDA_OE, TxUNDERRUN}, 2'b00);

        // Write 11, repeated START, read with no byte supplied in time.
        s0  = startCnt;
        so0 = sclOeCnt;
        sendStart();
        writeByte(8'hA0, ack, oe);
        writeByte(8'h11, ack, oe);
        checkVal("ur_write_ack", ack, 1'b1);
        sendRepStart();
`ifdef I2C_TARGET_STRETCH_EN
        fork
            begin
                writeByte(8'hA1, ack, oe);
                readByte(1'b1, b1);
            end
            supply(8'h5A, 60);
        join
        checkVal("ur_stretch_byte", b1, 8'h5A);
        checkVal("ur_stretch_seen", (sclOeCnt - so0) > 0, 1'b1);
        checkVal("ur_no_underrun", TxUNDERRUN, 1'b0);
`else
        writeByte(8'hA1, ack, oe);
        readByte(1'b1, b1);
        checkVal("ur_ff_byte", b1, 8'hFF);
        checkVal("ur_underrun", TxUNDERRUN, 1'b1);
        checkVal("ur_scl_never_held", sclOeCnt - so0, 0);
`endif
        checkVal("ur_read_addr_ack", ack, 1'b1);
        checkVal("ur_start_count", startCnt - s0, 2);
        checkVal("ur_rxdata", RxDATA, 8'h11);
        sendStop();

        // RESET in the middle of a write byte.
        sendStart();
        writeByte(8'hA0, ack, oe);
        checkVal("rst_pre_selected", Selected, 1'b1);
        bitXfer(1'b1, r, o);
        bitXfer(1'b0, r, o);
        bitXfer(1'b1, r, o);
        bitXfer(1'b0, r, o);
        RESET = 1'b1;
        clk(1);
        checkVal("rst_mid_byte_outputs", allOuts(), 18'h0);
        RESET = 1'b0;
        sdaM  = 1'b1;
        clk(2);
        sclM = 1'b1;
        clk(8);
        sendStart();
        writeByte(8'hA0, ack, oe);
        checkVal("rst_recover_ack", {ack, oe}, 2'b11);
        checkVal("rst_recover_selected", Selected, 1'b1);
        sendStop();

        // STOP after 5 bits of a data byte aborts it.
        sendStart();
        writeByte(8'hA0, ack, oe);
        rx0 = rxCnt;
        bitXfer(1'b1, r, o);
        bitXfer(1'b1, r, o);
        bitXfer(1'b0, r, o);
        bitXfer(1'b0, r, o);
        bitXfer(1'b0, r, o);
        st0 = stopCnt;
        sendStop();
        clk(20);
        checkVal("ab_no_rx", rxCnt - rx0, 0);
        checkVal("ab_stop_pulse", stopCnt - st0, 1);
        checkVal("ab_released", {Selected, SDA_OE}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Single-address I2C target (slave): the far end of the team's single-master I2C transceiver.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs, and delivers write bytes to local logic.
- Sources read bytes from local logic through a request/load handshake.
- Sits between the board-level I2C pads (open-drain mapping done externally) and a local register file or FIFO.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL_i/SDA_i (legal range 2-3).

Ports:
- CLK  input  1  system clock; must be at least 8x the SCL frequency.
- RESET  input  1  synchronous, active-high reset.
- SCL_i  input  1  raw SCL from pad.
- SDA_i  input  1  raw SDA from pad.
- SDA_o  output  1  SDA value to drive; meaningful only when SDA_OE=1.
- SDA_OE  output  1  1 = drive SDA_o onto the bus.
- SCL_OE  output  1  1 = pull SCL low (clock stretch); tied 0 unless I2C_TARGET_STRETCH_EN.
- RxDATA  output  8  last byte written by the master.
- RxVALID  output  1  one-CLK pulse: RxDATA updated.
- TxDATA  input  8  byte to return on a master read.
- TxREQ  output  1  one-CLK pulse: local logic must supply the next read byte.
- TxLOAD  input  1  one-CLK strobe capturing TxDATA.
- TxUNDERRUN  output  1  sticky: read byte was needed but no TxLOAD had arrived; cleared by RESET or START.
- MasterNACK  output  1  one-CLK pulse: master NACKed a read byte.
- Selected  output  1  high from address ACK until STOP or repeated START.
- StartDet  output  1  one-CLK pulse on START or repeated START.
- StopDet  output  1  one-CLK pulse on STOP.

Behaviour:
Reset and conditioning:
- RESET (any time, including mid-byte): all outputs 0 on the next CLK edge (SDA released, SCL released, RxDATA=8'h00); state IDLE; shift registers and bit counter cleared.
- SCL/SDA pass through SYNC_STAGES flops plus one history flop. Edge and condition detection latency is SYNC_STAGES+1 CLK from the pad.
- START/repeated START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Data bits: sampled on the SCL rising edge. SDA_o/SDA_OE change only on the CLK after a detected SCL falling edge.

State machine (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP):
- IDLE: on START -> ADDR, bit counter=0.
- ADDR: shift 8 bits MSB first; the 8th bit is R/W.
  - Address == SLAVE_ADDR -> ADDR_ACK.
  - Mismatch -> WAIT_STOP with SDA never driven.
- ADDR_ACK: from the 8th falling edge to the 9th falling edge, SDA_OE=1, SDA_o=0; Selected=1.
  - R/W=0 -> WRITE.
  - R/W=1 -> TxREQ pulses on ADDR_ACK entry; at the 9th falling edge, load the shift register and go to READ.
- WRITE: shift 8 bits. On the 8th falling edge: RxDATA <= byte, RxVALID pulse, -> WRITE_ACK (always ACK, SDA_o=0 for one bit).
  - On the 9th falling edge, release SDA and return to WRITE.
- READ: drive SDA_o=bit[7..0] (SDA_OE=1) from each falling edge. After bit 0, release SDA -> READ_ACK.
- READ_ACK: sample SDA on the 9th rising edge.
  - 0 (master ACK): TxREQ pulse, reload at the 9th falling edge, -> READ.
  - 1 (master NACK): MasterNACK pulse, -> WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.

Global conditions and boundaries:
- STOP in any state -> IDLE, SDA released, StopDet pulse, Selected=0.
- START in any state -> ADDR, StartDet pulse, TxUNDERRUN cleared.
- STOP or START detected mid-byte aborts the byte: no RxVALID, no ACK.
- Read byte source: TxLOAD captures TxDATA into a holding register, holding flag set. Reload consumes the holding register and clears the flag. If the flag is clear at reload: shift 8'hFF and set TxUNDERRUN.
- TxLOAD in the same cycle as a reload: the new TxDATA is used.
- Bit counter is 4-bit and wraps 8 -> 0 at each byte boundary; no byte-count limit.

Optional Feature:
- Macro: I2C_TARGET_STRETCH_EN.
- Defined: at a read reload with the holding flag clear, assert SCL_OE=1 (hold SCL low) until the CLK after TxLOAD, then load the byte, release SCL and continue. TxUNDERRUN is never set. STOP/START still abort and release SCL.
- Undefined: SCL_OE is constant 0; underrun sends 8'hFF as above.

Test Plan:
- Write 8'hA0 (addr 0x50, W), then 8'hA5, 8'h3C, then STOP -> three ACKs (SDA_OE=1/SDA_o=0 in each 9th bit), RxVALID pulses with RxDATA=A5 then 3C, StopDet pulse, Selected=0.
- Address 8'hA2 (0x51) -> SDA_OE stays 0 for the whole transaction, no RxVALID, Selected=0.
- Read 8'hA1; TxLOAD 8'h96 two CLKs after TxREQ; master ACK; TxLOAD 8'h0F; master NACK; STOP -> SDA bits 10010110 then 00001111, two TxREQ pulses, one MasterNACK, SDA released.
- Write 8'hA0 + 8'h11, repeated START, read 8'hA1 with no TxLOAD -> StartDet twice, RxDATA=11, SDA shifts FF, TxUNDERRUN=1 (stretch off). With I2C_TARGET_STRETCH_EN: SCL_OE=1 until TxLOAD 8'h5A, then 01011010 is shifted.
- RESET asserted at bit 4 of a write byte -> next CLK: all outputs 0; after release, a new START + 8'hA0 is ACKed normally.
- STOP injected after 5 bits of a data byte -> no RxVALID, IDLE, StopDet pulse.
